// File: rtl/cache_line_fill_if.sv
// rtl/cache_line_fill_if.sv - cache miss port and DRAM burst-read port bundle for cache_line_fill
interface cache_line_fill_if #(
  parameter int ADDR_W = 23,
  parameter int BEAT_W = 32,
  parameter int BEATS  = 8,
  parameter int CNT_W  = 16
);
  localparam int LINE_W = BEAT_W * BEATS;

  logic              mem_req;
  logic [ADDR_W-1:0] tag_index_mem;
  logic [LINE_W-1:0] line_in;
  logic              we_mem;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [BEAT_W-1:0] rd_data;
  logic              busy;
  logic [CNT_W-1:0]  fill_count;

  // master is the fill controller; slave is the cache/DRAM side driving it
  modport master (
    input  mem_req, tag_index_mem, rd_ack, rd_valid, rd_data,
    output line_in, we_mem, rd_req, rd_addr, busy, fill_count
  );

  modport slave (
    output mem_req, tag_index_mem, rd_ack, rd_valid, rd_data,
    input  line_in, we_mem, rd_req, rd_addr, busy, fill_count
  );
endinterface

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - line-fill controller: one 8-beat DRAM burst per cache miss, one-cycle line write
module cache_line_fill #(
  parameter int ADDR_W = 23,
  parameter int BEAT_W = 32,
  parameter int BEATS  = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_line_fill_if.master bus
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_req_q, rd_req_d;
  logic              we_q, we_d;
  logic              last_beat;

  assign last_beat = (beat_q == BC_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          addr_d  = {bus.tag_index_mem[ADDR_W-1:BC_W], {BC_W{1'b0}}};
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // once latched the request is committed; mem_req is no longer looked at
        if (bus.rd_ack) begin
          beat_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.rd_valid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BC_W'(k)) begin
              line_d[k*BEAT_W +: BEAT_W] = bus.rd_data;
            end
          end
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // registered outputs are decoded from the next state so they align with it
    rd_req_d = (state_d == S_REQ);
    we_d     = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      rd_req_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      rd_req_q <= rd_req_d;
      we_q     <= we_d;
    end
  end

  assign bus.rd_req     = rd_req_q;
  assign bus.rd_addr    = addr_q;
  assign bus.we_mem     = we_q;
  assign bus.line_in    = line_q;
  assign bus.fill_count = cnt_q;
  assign bus.busy       = (state_q != S_IDLE);

  a_we_single: assert property (@(posedge clk) disable iff (rst) bus.we_mem |=> !bus.we_mem);
  a_addr_align: assert property (@(posedge clk) disable iff (rst)
    bus.rd_req |-> (bus.rd_addr[BC_W-1:0] == '0));
endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - self-checking bench for cache_line_fill (16-bit and 2-bit counter instances)
module tb_cache_line_fill;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [22:0] tag;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fills = 0;

  always #5 clk = ~clk;

  cache_line_fill_if #(.CNT_W(16)) ifa ();
  cache_line_fill_if #(.CNT_W(2))  ifb ();

  assign ifa.mem_req = mem_req;
  assign ifa.tag_index_mem = tag;
  assign ifa.rd_ack = rd_ack;
  assign ifa.rd_valid = rd_valid;
  assign ifa.rd_data = rd_data;
  assign ifb.mem_req = mem_req;
  assign ifb.tag_index_mem = tag;
  assign ifb.rd_ack = rd_ack;
  assign ifb.rd_valid = rd_valid;
  assign ifb.rd_data = rd_data;

  cache_line_fill #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(ifa.master));
  cache_line_fill #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(ifb.master));

  typedef struct {
    logic [22:0] tg;
    int          dly;
    int          gmax;
    bit          spur;
    bit          drop;
    logic [22:0] xaddr;
    logic [31:0] base;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [255:0] sat16(input int n);
    return (n > 65535) ? 256'd65535 : 256'(n);
  endfunction

  function automatic logic [255:0] sat2(input int n);
    return (n > 3) ? 256'd3 : 256'(n);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy_cycle(input string tag_s, input logic exp_req, input logic [22:0] xaddr);
    chk({tag_s, "_busy"}, ifa.busy, 1);
    chk({tag_s, "_rd_req"}, ifa.rd_req, exp_req);
    chk({tag_s, "_we"}, ifa.we_mem, 0);
    if (exp_req) chk({tag_s, "_rd_addr"}, ifa.rd_addr, xaddr);
  endtask

  // One complete fill starting in an IDLE cycle; returns in the IDLE cycle after the write.
  task automatic fill(input logic [22:0] tg, input int dly, input int gmax, input bit rnd,
                      input bit spur, input bit drop, input logic [22:0] xaddr,
                      input logic [31:0] base);
    logic [31:0]  beats [8];
    logic [255:0] xline;
    int           gap;
    xline = '0;
    for (int k = 0; k < 8; k++) begin
      beats[k] = rnd ? $urandom : base + 32'(k);
      xline[k*32 +: 32] = beats[k];
    end
    chk("idle_busy", ifa.busy, 0);
    chk("idle_rd_req", ifa.rd_req, 0);
    chk("idle_we", ifa.we_mem, 0);
    mem_req = 1'b1; tag = tg; rd_ack = 1'b0; rd_valid = 1'b0;
    step();
    tag = 23'($urandom);
    if (drop) mem_req = 1'b0;
    for (int c = 0; c <= dly; c++) begin
      chk_busy_cycle("req", 1'b1, xaddr);
      rd_ack = (c == dly);
      rd_valid = spur ? 1'($urandom_range(1, 0)) : 1'b0;
      rd_data = $urandom;
      step();
    end
    for (int k = 0; k < 8; k++) begin
      gap = rnd ? int'($urandom_range(gmax, 0)) : (k % (gmax + 1));
      for (int g = 0; g < gap; g++) begin
        chk_busy_cycle("gap", 1'b0, xaddr);
        rd_valid = 1'b0; rd_data = $urandom; rd_ack = 1'($urandom_range(1, 0));
        step();
      end
      chk_busy_cycle("beat", 1'b0, xaddr);
      rd_valid = 1'b1; rd_data = beats[k]; rd_ack = 1'($urandom_range(1, 0));
      step();
    end
    mem_req = 1'b0;
    rd_valid = 1'($urandom_range(1, 0)); rd_data = $urandom; rd_ack = 1'($urandom_range(1, 0));
    chk("wr_we", ifa.we_mem, 1);
    chk("wr_line", ifa.line_in, xline);
    chk("wr_busy", ifa.busy, 1);
    chk("wr_rd_req", ifa.rd_req, 0);
    chk("wr_cnt_old", ifa.fill_count, sat16(n_fills));
    step();
    n_fills++;
    rd_valid = 1'b0; rd_ack = 1'b0;
    chk("post_we", ifa.we_mem, 0);
    chk("post_busy", ifa.busy, 0);
    chk("post_rd_addr_hold", ifa.rd_addr, xaddr);
    chk("post_cnt", ifa.fill_count, sat16(n_fills));
    chk("post_cnt_sat", ifb.fill_count, sat2(n_fills));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [22:0] rtag;
    vecs[0] = '{23'h012340, 0, 0, 1'b0, 1'b0, 23'h012340, 32'h000000A0};
    vecs[1] = '{23'h7FFFFF, 5, 0, 1'b0, 1'b0, 23'h7FFFF8, 32'hB0B0B000};
    vecs[2] = '{23'h00ABCD, 2, 3, 1'b1, 1'b0, 23'h00ABC8, 32'hC0DE0010};
    vecs[3] = '{23'h123457, 1, 1, 1'b0, 1'b1, 23'h123450, 32'hD00D0F00};
    vecs[4] = '{23'h000008, 0, 2, 1'b1, 1'b1, 23'h000008, 32'hE0E0E0F8};

    rst = 1'b1; mem_req = 1'b0; tag = '0; rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    step();
    step();
    chk("rst_busy", ifa.busy, 0);
    chk("rst_rd_req", ifa.rd_req, 0);
    chk("rst_we", ifa.we_mem, 0);
    chk("rst_line", ifa.line_in, 0);
    chk("rst_cnt", ifa.fill_count, 0);
    chk("rst_rd_addr", ifa.rd_addr, 0);
    rst = 1'b0;
    step();

    // back-to-back table fills; the 2-bit counter instance walks 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      fill(vecs[i].tg, vecs[i].dly, vecs[i].gmax, 1'b0, vecs[i].spur, vecs[i].drop,
           vecs[i].xaddr, vecs[i].base);
    end

    // reset in the middle of a burst after beat 4
    mem_req = 1'b1; tag = 23'h055555;
    step();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      rd_valid = 1'b1; rd_data = 32'hF00D0000 + 32'(k);
      step();
    end
    rd_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; mem_req = 1'b0;
    n_fills = 0;
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_rd_req", ifa.rd_req, 0);
    chk("mid_rst_we", ifa.we_mem, 0);
    chk("mid_rst_line", ifa.line_in, 0);
    chk("mid_rst_cnt", ifa.fill_count, 0);
    chk("mid_rst_cnt_sat", ifb.fill_count, 0);
    step();
    fill(23'h3ABCDE, 1, 0, 1'b0, 1'b0, 1'b0, 23'h3ABCD8, 32'h11110000);

    for (int i = 0; i < 20; i++) begin
      rtag = 23'($urandom);
      fill(rtag, int'($urandom_range(4, 0)), 3, 1'b1, 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), rtag & ~23'h7, 32'h0);
      repeat ($urandom_range(2, 0)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
